incr_share_arbiter: RTL

- Time-shares one WIDTH-bit ripple incrementer, built from the team's full_adder chain, between two requesters, A and B.
- Each requester presents an operand with a req/ack handshake. The block arbitrates round-robin, sequences the incrementer through a 3-state FSM, and returns a registered result tagged with the requester ID.
- Sits between requester logic and the shared increment datapath. It is the only driver of the incrementer's operand input.

---
 rtl/incr_share_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/incr_share_arbiter.sv
// rtl/incr_share_arbiter.sv - round-robin sharing of one ripple incrementer between requesters A and B
// Optional saturation of the result is enabled by defining INCR_SHARE_SAT_EN.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module incr_share_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] opnd_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] opnd_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic [WIDTH:0]   res,
  output logic             res_id,
  output logic             res_valid,
`ifdef INCR_SHARE_SAT_EN
  output logic             sat,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_q;
  logic             gnt_id_q;
  logic             last_gnt_q;
  logic [WIDTH:0]   res_q;
  logic             res_id_q;
  logic             load;
  logic             grant_b;

  // Increment is a full_adder chain with carry-in tied high and the B leg tied low.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] inc_sum;
  logic [WIDTH:0]   res_d;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_inc
    full_adder u_fa (
      .a_i (op_q[i]),
      .b_i (1'b0),
      .ci_i(carry[i]),
      .s_o (inc_sum[i]),
      .co_o(carry[i+1])
    );
  end

`ifdef INCR_SHARE_SAT_EN
  logic sat_q;
  logic sat_d;

  always_comb begin
    sat_d = carry[WIDTH];
    res_d = sat_d ? {1'b0, op_q} : {1'b0, inc_sum};
  end

  assign sat = sat_q & res_valid;
`else
  always_comb begin
    res_d = {carry[WIDTH], inc_sum};
  end
`endif

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    grant_b   = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    ack_a     = 1'b0;
    ack_b     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          // On a tie the requester that did not win last time goes first.
          grant_b = req_b && (!req_a || !last_gnt_q);
          load    = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        ack_a     = !gnt_id_q;
        ack_b     = gnt_id_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      gnt_id_q   <= 1'b0;
      last_gnt_q <= 1'b1;
      res_q      <= '0;
      res_id_q   <= 1'b0;
`ifdef INCR_SHARE_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load) begin
        op_q       <= grant_b ? opnd_b : opnd_a;
        gnt_id_q   <= grant_b;
        last_gnt_q <= grant_b;
      end
      if (state_q == S_EXEC) begin
        res_q    <= res_d;
        res_id_q <= gnt_id_q;
`ifdef INCR_SHARE_SAT_EN
        sat_q    <= sat_d;
`endif
      end
    end
  end

  assign res    = res_q;
  assign res_id = res_id_q;

endmodule
